// File: rtl/sp16_fifo_ctrl.sv
// sp16_fifo_ctrl: valid/ready FIFO controller in front of a single-port
// 16-word async-read RAM, plus a one-word output register (17 deep total).
//
// Ports
//   CLK, RESETN       clock (shared with RAM), async active-low reset
//   I_VALID/I_READY   upstream handshake, I_DATA upstream word
//   O_VALID/O_READY   downstream handshake, O_DATA registered head word
//   LEVEL             occupancy 0..17 (RAM count + O_VALID)
//   RAM_WRE/RAM_AD    RAM write enable and shared read/write address
//   RAM_DI/RAM_DO     RAM write data (= I_DATA) and async read data
module sp16_fifo_ctrl #(
   parameter int WIDTH = 2
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             I_VALID,
   output logic             I_READY,
   input  logic [WIDTH-1:0] I_DATA,
   output logic             O_VALID,
   input  logic             O_READY,
   output logic [WIDTH-1:0] O_DATA,
   output logic [4:0]       LEVEL,
   output logic             RAM_WRE,
   output logic [3:0]       RAM_AD,
   output logic [WIDTH-1:0] RAM_DI,
   input  logic [WIDTH-1:0] RAM_DO
);

   typedef enum logic [1:0] {
      M_IDLE,
      M_READ,
      M_BYPASS,
      M_WRITE
   } mode_t;

   logic [3:0]       wptr;
   logic [3:0]       rptr;
   logic [4:0]       cnt;
   logic             o_valid;
   logic [WIDTH-1:0] o_data;

   logic  drain;
   logic  rd_sel;
   logic  bypass;
   logic  ram_empty;
   logic  ram_full;
   logic  in_ready;
   logic  wre;
   mode_t mode;

   assign ram_empty = (cnt == 5'd0);
   assign ram_full  = (cnt == 5'd16);

   // Output register is free now or frees at this edge.
   assign drain  = !o_valid || O_READY;

   // The single address port goes to the read whenever the
   // output register can take the RAM head; writes wait.
   assign rd_sel = drain && !ram_empty;

   // Only when the RAM is empty may a new word skip it,
   // so an older RAM word is never overtaken.
   assign bypass = drain && ram_empty;

   assign in_ready = bypass || (!rd_sel && !ram_full);
   assign wre      = I_VALID && in_ready && !bypass;

   always_comb begin
      mode = M_IDLE;
      unique case (1'b1)
         rd_sel:             mode = M_READ;
         bypass && I_VALID:  mode = M_BYPASS;
         wre:                mode = M_WRITE;
         default:            mode = M_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         wptr    <= 4'd0;
         rptr    <= 4'd0;
         cnt     <= 5'd0;
         o_valid <= 1'b0;
         o_data  <= '0;
      end else begin
         unique case (mode)
            M_READ: begin
               o_data  <= RAM_DO;
               o_valid <= 1'b1;
               rptr    <= rptr + 4'd1;
               cnt     <= cnt - 5'd1;
            end
            M_BYPASS: begin
               o_data  <= I_DATA;
               o_valid <= 1'b1;
            end
            M_WRITE: begin
               wptr <= wptr + 4'd1;
               cnt  <= cnt + 5'd1;
            end
            default: begin
               // O_DATA is kept; only the valid flag drops.
               if (o_valid && O_READY)
                  o_valid <= 1'b0;
            end
         endcase
      end
   end

   assign I_READY = in_ready;
   assign O_VALID = o_valid;
   assign O_DATA  = o_data;
   assign LEVEL   = cnt + {4'd0, o_valid};
   assign RAM_WRE = wre;
   assign RAM_AD  = rd_sel ? rptr : wptr;
   assign RAM_DI  = I_DATA;

endmodule

// File: tb/tb_sp16_fifo_ctrl.sv
// tb_sp16_fifo_ctrl: directed bench for sp16_fifo_ctrl with a behavioural
// 16x2 async-read RAM model and a reference queue for the random phase.
module tb_sp16_fifo_ctrl;

   logic       CLK = 1'b0;
   logic       RESETN;
   logic       I_VALID;
   logic       I_READY;
   logic [1:0] I_DATA;
   logic       O_VALID;
   logic       O_READY;
   logic [1:0] O_DATA;
   logic [4:0] LEVEL;
   logic       RAM_WRE;
   logic [3:0] RAM_AD;
   logic [1:0] RAM_DI;
   logic [1:0] RAM_DO;

   logic [1:0] mem [16];

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   always @(posedge CLK)
      if (RAM_WRE) mem[RAM_AD] <= RAM_DI;

   assign RAM_DO = mem[RAM_AD];

   sp16_fifo_ctrl #(.WIDTH(2)) dut (
      .CLK     (CLK),
      .RESETN  (RESETN),
      .I_VALID (I_VALID),
      .I_READY (I_READY),
      .I_DATA  (I_DATA),
      .O_VALID (O_VALID),
      .O_READY (O_READY),
      .O_DATA  (O_DATA),
      .LEVEL   (LEVEL),
      .RAM_WRE (RAM_WRE),
      .RAM_AD  (RAM_AD),
      .RAM_DI  (RAM_DI),
      .RAM_DO  (RAM_DO)
   );

   // Inputs change at posedge+1, outputs are sampled at posedge+2.
   task automatic drive(input logic iv, input logic [1:0] id,
                        input logic ordy);
      I_VALID = iv;
      I_DATA  = id;
      O_READY = ordy;
      #1;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_reset();
      RESETN  = 1'b0;
      I_VALID = 1'b0;
      I_DATA  = 2'd0;
      O_READY = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RESETN = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      drive(1'b0, 2'd0, 1'b0);
      checks++;
      if (O_VALID !== 1'b0 || LEVEL !== 5'd0 || I_READY !== 1'b1 ||
          O_DATA !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got v=%b lvl=%0d rdy=%b d=%0d want v=0 lvl=0 rdy=1 d=0",
                  O_VALID, LEVEL, I_READY, O_DATA);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 2'(i), 1'b0);
         tick();
      end
      checks++;
      if (LEVEL !== 5'd4) begin
         errors++;
         $display("FAIL midrst_pre_level: got %0d want 4", LEVEL);
      end
      RESETN = 1'b0;
      #1;
      checks++;
      if (O_VALID !== 1'b0 || LEVEL !== 5'd0 || I_READY !== 1'b1) begin
         errors++;
         $display("FAIL midrst_async: got v=%b lvl=%0d rdy=%b want v=0 lvl=0 rdy=1",
                  O_VALID, LEVEL, I_READY);
      end
      I_VALID = 1'b0;
      tick();
      RESETN = 1'b1;
   endtask

   task automatic test_bypass();
      apply_reset();
      drive(1'b1, 2'b10, 1'b1);
      checks++;
      if (I_READY !== 1'b1 || RAM_WRE !== 1'b0) begin
         errors++;
         $display("FAIL bypass_accept: got rdy=%b wre=%b want rdy=1 wre=0",
                  I_READY, RAM_WRE);
      end
      tick();
      drive(1'b0, 2'd0, 1'b0);
      checks++;
      if (O_VALID !== 1'b1 || O_DATA !== 2'b10 || LEVEL !== 5'd1 ||
          RAM_WRE !== 1'b0) begin
         errors++;
         $display("FAIL bypass_out: got v=%b d=%0d lvl=%0d wre=%b want v=1 d=2 lvl=1 wre=0",
                  O_VALID, O_DATA, LEVEL, RAM_WRE);
      end
      drive(1'b0, 2'd0, 1'b1);
      tick();
      checks++;
      if (O_VALID !== 1'b0 || LEVEL !== 5'd0 || O_DATA !== 2'b10) begin
         errors++;
         $display("FAIL bypass_pop: got v=%b lvl=%0d d=%0d want v=0 lvl=0 d=2",
                  O_VALID, LEVEL, O_DATA);
      end
   endtask

   task automatic test_fill();
      int acc;
      apply_reset();
      acc = 0;
      for (int c = 0; c < 20; c++) begin
         drive(1'b1, 2'(acc % 4), 1'b0);
         if (I_READY) acc++;
         tick();
      end
      drive(1'b1, 2'(acc % 4), 1'b0);
      checks++;
      if (acc != 17) begin
         errors++;
         $display("FAIL fill_accepted: got %0d want 17", acc);
      end
      checks++;
      if (LEVEL !== 5'd17 || I_READY !== 1'b0 || RAM_WRE !== 1'b0) begin
         errors++;
         $display("FAIL fill_full: got lvl=%0d rdy=%b wre=%b want lvl=17 rdy=0 wre=0",
                  LEVEL, I_READY, RAM_WRE);
      end
      checks++;
      if (O_VALID !== 1'b1 || O_DATA !== 2'd0) begin
         errors++;
         $display("FAIL fill_head: got v=%b d=%0d want v=1 d=0", O_VALID, O_DATA);
      end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (mem[k] !== 2'((k + 1) % 4)) begin
            errors++;
            $display("FAIL fill_ram[%0d]: got %0d want %0d", k, mem[k], (k + 1) % 4);
         end
      end
   endtask

   // Continues from the full state left by test_fill.
   task automatic test_drain();
      for (int k = 0; k < 17; k++) begin
         drive(1'b0, 2'd0, 1'b1);
         checks++;
         if (O_VALID !== 1'b1 || O_DATA !== 2'(k % 4) ||
             LEVEL !== 5'(17 - k)) begin
            errors++;
            $display("FAIL drain_word[%0d]: got v=%b d=%0d lvl=%0d want v=1 d=%0d lvl=%0d",
                     k, O_VALID, O_DATA, LEVEL, k % 4, 17 - k);
         end
         tick();
      end
      drive(1'b0, 2'd0, 1'b1);
      checks++;
      if (O_VALID !== 1'b0 || LEVEL !== 5'd0) begin
         errors++;
         $display("FAIL drain_empty: got v=%b lvl=%0d want v=0 lvl=0", O_VALID, LEVEL);
      end
   endtask

   task automatic test_random();
      logic [1:0] q[$];
      logic [1:0] w;
      int pushed;
      int cyc;
      apply_reset();
      pushed = 0;
      w = 2'($urandom);
      for (cyc = 0; cyc < 600 && (pushed < 40 || q.size() != 0); cyc++) begin
         drive((pushed < 40) && ($urandom_range(3) != 0), w,
               (pushed >= 40) || ($urandom_range(1) == 1));
         checks++;
         if (int'(LEVEL) != q.size()) begin
            errors++;
            $display("FAIL rand_level cyc %0d: got %0d want %0d", cyc, LEVEL, q.size());
         end
         checks++;
         if (RAM_WRE && (!O_VALID || O_READY) && (LEVEL != {4'd0, O_VALID})) begin
            errors++;
            $display("FAIL rand_priority cyc %0d: got wre=1 with read pending want wre=0", cyc);
         end
         if (O_VALID && O_READY) begin
            checks++;
            if (q.size() == 0 || O_DATA !== q[0]) begin
               errors++;
               $display("FAIL rand_data cyc %0d: got %0d want %0d", cyc, O_DATA,
                        (q.size() == 0) ? 2'd0 : q[0]);
            end
            if (q.size() != 0) void'(q.pop_front());
         end
         if (I_VALID && I_READY) begin
            q.push_back(w);
            pushed++;
            w = 2'($urandom);
         end
         tick();
      end
      checks++;
      if (pushed != 40 || q.size() != 0) begin
         errors++;
         $display("FAIL rand_timeout: got pushed=%0d left=%0d want pushed=40 left=0",
                  pushed, q.size());
      end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      drive(1'b1, 2'd1, 1'b0);
      tick();
      drive(1'b1, 2'd3, 1'b1);
      checks++;
      if (O_VALID !== 1'b1 || O_DATA !== 2'd1 || I_READY !== 1'b1 ||
          RAM_WRE !== 1'b0) begin
         errors++;
         $display("FAIL simul_pre: got v=%b d=%0d rdy=%b wre=%b want v=1 d=1 rdy=1 wre=0",
                  O_VALID, O_DATA, I_READY, RAM_WRE);
      end
      tick();
      drive(1'b0, 2'd0, 1'b0);
      checks++;
      if (O_VALID !== 1'b1 || O_DATA !== 2'd3 || LEVEL !== 5'd1) begin
         errors++;
         $display("FAIL simul_post: got v=%b d=%0d lvl=%0d want v=1 d=3 lvl=1",
                  O_VALID, O_DATA, LEVEL);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp;
      int got;
      apply_reset();
      drive(1'b1, 2'd2, 1'b0);
      tick();
      drive(1'b1, 2'd1, 1'b0);
      tick();
      drive(1'b1, 2'd3, 1'b0);
      tick();
      got = 0;
      for (int c = 0; c < 8 && got < 3; c++) begin
         drive(1'b0, 2'd0, 1'b1);
         if (O_VALID) begin
            exp = (got == 0) ? 2'd2 : (got == 1) ? 2'd1 : 2'd3;
            checks++;
            if (O_DATA !== exp) begin
               errors++;
               $display("FAIL b2b_word[%0d]: got %0d want %0d", got, O_DATA, exp);
            end
            got++;
         end
         tick();
      end
      checks++;
      if (got != 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d want 3", got);
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_fill();
      test_drain();
      test_reset_mid();
      test_random();
      test_simultaneous();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
